// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester data memory port arbiter, round-robin with bounded lock bursts
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} own_t;

    own_t          own_q, own_d;
    logic          last_q, last_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [HW-1:0] hold_inc;
    logic          rvalid0_q, rvalid1_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

    assign hold_inc = hold_q + 1'b1;

    // Grants: last_q==1 means m1 went last, so m0 takes the tie.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst) begin
            case (own_q)
                IDLE: begin
                    if (m0_req && m1_req) begin
                        m0_gnt = last_q;
                        m1_gnt = !last_q;
                    end else begin
                        m0_gnt = m0_req;
                        m1_gnt = m1_req;
                    end
                end
                OWN0:    m0_gnt = m0_req;
                OWN1:    m1_gnt = m1_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        own_d  = own_q;
        hold_d = hold_q;
        last_d = last_q;
        if (m0_gnt) begin
            last_d = 1'b0;
        end else if (m1_gnt) begin
            last_d = 1'b1;
        end
        case (own_q)
            IDLE: begin
                if (m0_gnt && m0_lock) begin
                    own_d  = OWN0;
                    hold_d = HW'(1);
                end else if (m1_gnt && m1_lock) begin
                    own_d  = OWN1;
                    hold_d = HW'(1);
                end
            end
            // Owner idling, unlocking or hitting the hold limit all release.
            OWN0: begin
                if (m0_gnt && m0_lock && (hold_inc < HOLD_MAX)) begin
                    hold_d = hold_inc;
                end else begin
                    own_d  = IDLE;
                    hold_d = '0;
                end
            end
            OWN1: begin
                if (m1_gnt && m1_lock && (hold_inc < HOLD_MAX)) begin
                    hold_d = hold_inc;
                end else begin
                    own_d  = IDLE;
                    hold_d = '0;
                end
            end
            default: begin
                own_d  = IDLE;
                hold_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            own_q     <= IDLE;
            last_q    <= 1'b1;
            hold_q    <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            own_q     <= own_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            rvalid0_q <= m0_gnt && !m0_we;
            rvalid1_q <= m1_gnt && !m1_we;
            if (m0_gnt && !m0_we) begin
                rdata0_q <= mem_rd;
            end
            if (m1_gnt && !m1_we) begin
                rdata1_q <= mem_rd;
            end
        end
    end

    // A read accepted just before reset must not surface during the reset cycle.
    assign m0_rvalid = rvalid0_q && !rst;
    assign m1_rvalid = rvalid1_q && !rst;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

    assign mem_we = (m0_gnt && m0_we) || (m1_gnt && m1_we);
    assign mem_a  = m0_gnt ? m0_addr  : (m1_gnt ? m1_addr  : '0);
    assign mem_wd = m0_gnt ? m0_wdata : (m1_gnt ? m1_wdata : '0);
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed vector bench for dmem_arbiter
module tb_dmem_arbiter;
    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] mem [0:255];
    int errors = 0;
    int checks = 0;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_HOLD(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[9:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_a[9:2]] <= mem_wd;
    end

    typedef struct {
        logic        r0, we0, lk0;
        logic [31:0] a0;
        logic        r1, we1, lk1;
        logic [31:0] a1, wd1;
        logic        eg0, eg1, ewe;
        logic [31:0] ea;
        logic        erv0;
        logic [31:0] erd0;
        logic        erv1;
        logic [31:0] erd1;
    } vec_t;

    vec_t tbl [0:16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;

        //          r0 we0 lk0 a0      r1 we1 lk1 a1      wd1           g0 g1 we ea      rv0 rd0           rv1 rd1
        tbl[0]  = '{1, 0, 0, 32'h10, 1, 0, 0, 32'h20, 32'h0,        1, 0, 0, 32'h10, 0, 32'h0,        0, 32'h0};
        tbl[1]  = '{1, 0, 0, 32'h14, 1, 0, 0, 32'h20, 32'h0,        0, 1, 0, 32'h20, 1, 32'h10000004, 0, 32'h0};
        tbl[2]  = '{1, 0, 0, 32'h14, 1, 0, 0, 32'h24, 32'h0,        1, 0, 0, 32'h14, 0, 32'h10000004, 1, 32'h10000008};
        tbl[3]  = '{1, 0, 0, 32'h18, 1, 0, 0, 32'h24, 32'h0,        0, 1, 0, 32'h24, 1, 32'h10000005, 0, 32'h10000008};
        tbl[4]  = '{0, 0, 0, 32'h0,  1, 1, 0, 32'h40, 32'hDEADBEEF, 0, 1, 1, 32'h40, 0, 32'h10000005, 1, 32'h10000009};
        tbl[5]  = '{1, 0, 0, 32'h40, 0, 0, 0, 32'h0,  32'h0,        1, 0, 0, 32'h40, 0, 32'h10000005, 0, 32'h10000009};
        tbl[6]  = '{0, 0, 0, 32'h0,  0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  1, 32'hDEADBEEF, 0, 32'h10000009};
        tbl[7]  = '{0, 0, 0, 32'h0,  1, 0, 0, 32'h44, 32'h0,        0, 1, 0, 32'h44, 0, 32'hDEADBEEF, 0, 32'h10000009};
        tbl[8]  = '{1, 0, 1, 32'h00, 1, 0, 0, 32'h48, 32'h0,        1, 0, 0, 32'h00, 0, 32'hDEADBEEF, 1, 32'h10000011};
        tbl[9]  = '{1, 0, 1, 32'h04, 1, 0, 0, 32'h48, 32'h0,        1, 0, 0, 32'h04, 1, 32'h10000000, 0, 32'h10000011};
        tbl[10] = '{1, 0, 0, 32'h08, 1, 0, 0, 32'h48, 32'h0,        1, 0, 0, 32'h08, 1, 32'h10000001, 0, 32'h10000011};
        tbl[11] = '{0, 0, 0, 32'h0,  1, 0, 0, 32'h48, 32'h0,        0, 1, 0, 32'h48, 1, 32'h10000002, 0, 32'h10000011};
        tbl[12] = '{0, 0, 0, 32'h0,  0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  0, 32'h10000002, 1, 32'h10000012};
        tbl[13] = '{1, 0, 0, 32'h0c, 1, 0, 1, 32'h4c, 32'h0,        1, 0, 0, 32'h0c, 0, 32'h10000002, 0, 32'h10000012};
        tbl[14] = '{1, 0, 0, 32'h10, 1, 0, 1, 32'h4c, 32'h0,        0, 1, 0, 32'h4c, 1, 32'h10000003, 0, 32'h10000012};
        tbl[15] = '{1, 0, 0, 32'h10, 1, 0, 0, 32'h50, 32'h0,        0, 1, 0, 32'h50, 0, 32'h10000003, 1, 32'h10000013};
        tbl[16] = '{1, 0, 0, 32'h10, 1, 0, 0, 32'h54, 32'h0,        1, 0, 0, 32'h10, 0, 32'h10000003, 1, 32'h10000014};

        // reset: requests (with writes) pending must see no grant
        idle_inputs();
        rst = 1;
        m0_req = 1; m0_we = 1; m1_req = 1; m1_we = 1;
        m0_addr = 32'h8; m1_addr = 32'hC;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("rst%0d_gnt0", c), {31'b0, m0_gnt}, 32'd0);
            chk($sformatf("rst%0d_gnt1", c), {31'b0, m1_gnt}, 32'd0);
            chk($sformatf("rst%0d_mem_we", c), {31'b0, mem_we}, 32'd0);
            chk($sformatf("rst%0d_mem_a", c), mem_a, 32'd0);
            chk($sformatf("rst%0d_rvalid0", c), {31'b0, m0_rvalid}, 32'd0);
            chk($sformatf("rst%0d_rvalid1", c), {31'b0, m1_rvalid}, 32'd0);
        end
        @(posedge clk);
        #1 rst = 0;
        idle_inputs();

        for (int i = 0; i < 17; i++) begin
            m0_req = tbl[i].r0; m0_we = tbl[i].we0; m0_lock = tbl[i].lk0; m0_addr = tbl[i].a0;
            m1_req = tbl[i].r1; m1_we = tbl[i].we1; m1_lock = tbl[i].lk1; m1_addr = tbl[i].a1;
            m1_wdata = tbl[i].wd1;
            @(negedge clk);
            chk($sformatf("v%0d_gnt0", i), {31'b0, m0_gnt}, {31'b0, tbl[i].eg0});
            chk($sformatf("v%0d_gnt1", i), {31'b0, m1_gnt}, {31'b0, tbl[i].eg1});
            chk($sformatf("v%0d_mem_we", i), {31'b0, mem_we}, {31'b0, tbl[i].ewe});
            chk($sformatf("v%0d_mem_a", i), mem_a, tbl[i].ea);
            chk($sformatf("v%0d_rvalid0", i), {31'b0, m0_rvalid}, {31'b0, tbl[i].erv0});
            chk($sformatf("v%0d_rdata0", i), m0_rdata, tbl[i].erd0);
            chk($sformatf("v%0d_rvalid1", i), {31'b0, m1_rvalid}, {31'b0, tbl[i].erv1});
            chk($sformatf("v%0d_rdata1", i), m1_rdata, tbl[i].erd1);
            if (tbl[i].ewe) chk($sformatf("v%0d_mem_wd", i), mem_wd, tbl[i].wd1);
            @(posedge clk);
            #1;
        end

        // hold limit: continuous lock yields exactly 8 grants, then m1, then m0
        do_reset();
        m0_req = 1; m0_lock = 1; m0_addr = 32'h0;
        m1_req = 1; m1_addr = 32'h4;
        for (int c = 0; c < 10; c++) begin
            logic exp0;
            exp0 = (c < 8) || (c == 9);
            @(negedge clk);
            chk($sformatf("hold%0d_gnt0", c), {31'b0, m0_gnt}, {31'b0, exp0});
            chk($sformatf("hold%0d_gnt1", c), {31'b0, m1_gnt}, {31'b0, !exp0});
            @(posedge clk);
            #1;
        end

        // reset mid-burst: pending rvalid dropped, ownership and tie order reset
        do_reset();
        m0_req = 1; m0_lock = 1; m0_addr = 32'h0;
        m1_req = 1; m1_addr = 32'h4;
        @(negedge clk);
        chk("mid_pre_gnt0", {31'b0, m0_gnt}, 32'd1);
        @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        chk("mid_rst_rvalid0", {31'b0, m0_rvalid}, 32'd0);
        chk("mid_rst_gnt0", {31'b0, m0_gnt}, 32'd0);
        chk("mid_rst_gnt1", {31'b0, m1_gnt}, 32'd0);
        @(posedge clk);
        #1 rst = 0;
        m0_lock = 0;
        @(negedge clk);
        chk("mid_post_rvalid0", {31'b0, m0_rvalid}, 32'd0);
        chk("mid_post_rvalid1", {31'b0, m1_rvalid}, 32'd0);
        chk("mid_post_gnt0", {31'b0, m0_gnt}, 32'd1);
        chk("mid_post_gnt1", {31'b0, m1_gnt}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_next_gnt1", {31'b0, m1_gnt}, 32'd1);
        chk("mid_next_rvalid0", {31'b0, m0_rvalid}, 32'd1);
        chk("mid_next_rdata0", m0_rdata, 32'h10000000);
        @(posedge clk);
        #1 idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
